// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and helpers for the sequential divider
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must hold the value WIDTH itself
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// rtl/seq_divider_step.sv - one restoring-division iteration (compare, subtract, shift)
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;

    // The compare is WIDTH+1 bits wide so divisors with the MSB set are handled;
    // when partial >= divisor the difference is below divisor, so WIDTH bits suffice.
    always_comb begin
        partial = {rem_in, next_bit};
        q_bit   = (partial >= {1'b0, divisor});
        diff    = partial[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, optional signed mode via SEQ_DIVIDER_SIGNED_EN
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd_q;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             div_zero_in;
    logic [WIDTH-1:0] dvd_in, dvs_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_final, rem_final;

    assign accept      = (state == IDLE) && start_i;
    assign div_zero_in = (divisor_i == '0);
    assign quo_next    = {dvd_q[WIDTH-2:0], step_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_q, neg_r_q;
    logic dvd_neg, dvs_neg;

    // Divide magnitudes; the sign of each result is restored on the way into DONE
    always_comb begin
        dvd_neg   = signed_i & dividend_i[WIDTH-1];
        dvs_neg   = signed_i & divisor_i[WIDTH-1];
        dvd_in    = dvd_neg ? -dividend_i : dividend_i;
        dvs_in    = dvs_neg ? -divisor_i  : divisor_i;
        quo_final = neg_q_q ? -quo_next : quo_next;
        rem_final = neg_r_q ? -step_rem : step_rem;
    end

    // Result sign flags captured with the operands
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= dvd_neg ^ dvs_neg;
            neg_r_q <= dvd_neg;
        end
    end
`else
    // Unsigned only: operands and results pass straight through
    always_comb begin
        dvd_in    = dividend_i;
        dvs_in    = divisor_i;
        quo_final = quo_next;
        rem_final = step_rem;
    end
`endif

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; a zero divisor skips the iterations entirely
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start_i ? (div_zero_in ? DONE : OP) : IDLE;
            OP:      state_next = (cnt_q == CW'(1)) ? DONE : OP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready_o = (state == IDLE);
        done_o  = (state == DONE);
    end

    // Datapath: operand capture, one iteration per OP cycle, result registers updated at completion
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else if (accept) begin
            dvd_q      <= dvd_in;
            dvs_q      <= dvs_in;
            rem_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            div_zero_o <= div_zero_in;
            if (div_zero_in) begin
                quotient_o  <= '1;
                remainder_o <= dividend_i;
            end
        end else if (state == OP) begin
            dvd_q <= quo_next;
            rem_q <= step_rem;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                quotient_o  <= quo_final;
                remainder_o <= rem_final;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, ready32, done32, dz32;
    logic [31:0] a32, b32, q32, r32;
    logic        start8, ready8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic        sgn32, sgn8;
`endif

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   n_checks = 0;
    int   n_err    = 0;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start32),
        .dividend_i  (a32),
        .divisor_i   (b32),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_i    (sgn32),
`endif
        .ready_o     (ready32),
        .done_o      (done32),
        .quotient_o  (q32),
        .remainder_o (r32),
        .div_zero_o  (dz32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start8),
        .dividend_i  (a8),
        .divisor_i   (b8),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_i    (sgn8),
`endif
        .ready_o     (ready8),
        .done_o      (done8),
        .quotient_o  (q8),
        .remainder_o (r8),
        .div_zero_o  (dz8)
    );

    // Reference model: truncating division on 64-bit host arithmetic
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int w, input bit s);
        exp_t        e;
        logic [63:0] mask;
        longint      sa, sbv, qs, rs;
        mask = (64'd1 << w) - 64'd1;
        e.dz = (b == 64'd0);
        if (b == 64'd0) begin
            e.q = mask;
            e.r = a & mask;
        end else if (s) begin
            sa  = $signed(a << (64 - w));
            sa  = sa >>> (64 - w);
            sbv = $signed(b << (64 - w));
            sbv = sbv >>> (64 - w);
            qs  = sa / sbv;
            rs  = sa % sbv;
            e.q = 64'(qs) & mask;
            e.r = 64'(rs) & mask;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive one request to dut32, pass the accepting edge, then wait for done
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push,
                         output int lat, output logic rdy1);
        @(posedge clk); #1;
        a32 = a; b32 = b; start32 = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn32 = s;
`endif
        if (push) sb32.push_back(model(64'(a), 64'(b), 32, s));
        @(posedge clk); #1;
        start32 = 1'b0;
        lat  = 0;
        rdy1 = 1'bx;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) rdy1 = ready32;
            if (done32 === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn32 = 1'b0; sgn8 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (ready32 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready32); end
        n_checks++; if (done32 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done32); end
        n_checks++; if (q32 !== 32'd0) begin n_err++; $display("FAIL reset_quotient: got %h want 0", q32); end
        n_checks++; if (r32 !== 32'd0) begin n_err++; $display("FAIL reset_remainder: got %h want 0", r32); end
        n_checks++; if (dz32 !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b want 0", dz32); end
        n_checks++;
        if ({ready8, done8, q8, r8, dz8} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_w8: got rdy=%b done=%b q=%h r=%h dz=%b want 1 0 0 0 0", ready8, done8, q8, r8, dz8);
        end
    endtask

    task automatic test_basic;
        int   lat;
        logic rdy1;
        exp_t e;
        run32(32'd100, 32'd7, 1'b0, 1'b1, lat, rdy1);
        e = sb32.pop_front();
        n_checks++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL basic_ready_fall: got %b want 0", rdy1); end
        n_checks++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d want 33", lat); end
        n_checks++;
        if ({q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
            n_err++; $display("FAIL basic_result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
        end
        @(negedge clk);
        n_checks++;
        if ({ready32, done32} !== 2'b10) begin
            n_err++; $display("FAIL basic_ready_return: got rdy=%b done=%b want rdy=1 done=0", ready32, done32);
        end
    endtask

    task automatic test_msb_divisor;
        int   lat;
        logic rdy1;
        exp_t e;
        run32(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, lat, rdy1);
        e = sb32.pop_front();
        n_checks++; if (lat !== 33) begin n_err++; $display("FAIL msb_latency: got %0d want 33", lat); end
        n_checks++;
        if ({q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
            n_err++; $display("FAIL msb_result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
        end
    endtask

    task automatic test_div_zero;
        int   lat;
        logic rdy1;
        exp_t e;
        run32(32'd5, 32'd0, 1'b0, 1'b1, lat, rdy1);
        e = sb32.pop_front();
        n_checks++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_checks++;
        if ({q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
            n_err++; $display("FAIL dz_result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
        end
    endtask

    task automatic test_hold;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({ready32, q32, r32, dz32} !== {1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            n_err++; $display("FAIL hold_results: got rdy=%b q=%h r=%h dz=%b want 1 ffffffff 00000005 1", ready32, q32, r32, dz32);
        end
    endtask

    task automatic test_random;
        int          lat;
        logic        rdy1;
        exp_t        e;
        logic [31:0] a, b;
        for (int k = 0; k < 5; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run32(a, b, 1'b0, 1'b1, lat, rdy1);
            e = sb32.pop_front();
            n_checks++;
            if (lat == 0 || {q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
                n_err++; $display("FAIL random_%0d %h/%h: lat=%0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                  k, a, b, lat, q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
            end
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed;
        int          lat;
        logic        rdy1;
        exp_t        e;
        logic [31:0] av[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] bv[4] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        for (int k = 0; k < 4; k++) begin
            run32(av[k], bv[k], 1'b1, 1'b1, lat, rdy1);
            e = sb32.pop_front();
            n_checks++;
            if (lat !== ((bv[k] == 32'd0) ? 1 : 33) || {q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
                n_err++; $display("FAIL signed_%0d %h/%h: lat=%0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                                  k, av[k], bv[k], lat, q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
            end
        end
        sgn32 = 1'b0;
    endtask
`endif

    // dut8: start held high through OP and DONE, re-accepted once on return to IDLE
    task automatic test_back_to_back;
        int   ndone = 0;
        int   lat1 = 0;
        int   lat2 = 0;
        exp_t e;
        @(posedge clk); #1;
        a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        sb8.push_back(model(64'd200, 64'd3, 8, 1'b0));
        @(posedge clk); #1;
        a8 = 8'd255; b8 = 8'd16;
        sb8.push_back(model(64'd255, 64'd16, 8, 1'b0));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone++;
                if (ndone == 1) lat1 = i; else lat2 = i;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_done: unexpected done at cycle %0d", i);
                end else begin
                    e = sb8.pop_front();
                    if ({q8, r8, dz8} !== {e.q[7:0], e.r[7:0], e.dz}) begin
                        n_err++; $display("FAIL b2b_result_%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                                          ndone, q8, r8, dz8, e.q[7:0], e.r[7:0], e.dz);
                    end
                end
            end
            if (ready8 === 1'b1 && start8 === 1'b1) begin
                @(posedge clk); #1;
                start8 = 1'b0;
            end
        end
        n_checks++; if (lat1 !== 9) begin n_err++; $display("FAIL b2b_latency: got %0d want 9", lat1); end
        n_checks++; if (lat2 - lat1 !== 10) begin n_err++; $display("FAIL b2b_throughput: got %0d want 10", lat2 - lat1); end
        n_checks++; if (ndone !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    endtask

    task automatic test_reset_abort;
        int   lat;
        int   stray = 0;
        logic rdy1;
        exp_t e;
        @(posedge clk); #1;
        a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ready32, done32, q32, r32, dz32} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
            n_err++; $display("FAIL abort_state: got rdy=%b done=%b q=%h r=%h dz=%b want 1 0 0 0 0", ready32, done32, q32, r32, dz32);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32 === 1'b1) stray++;
        end
        n_checks++; if (stray !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d done pulses want 0", stray); end
        run32(32'd9, 32'd3, 1'b0, 1'b1, lat, rdy1);
        e = sb32.pop_front();
        n_checks++;
        if (lat !== 33 || {q32, r32, dz32} !== {e.q[31:0], e.r[31:0], e.dz}) begin
            n_err++; $display("FAIL abort_followup: lat=%0d got q=%h r=%h dz=%b want lat=33 q=%h r=%h dz=%b",
                              lat, q32, r32, dz32, e.q[31:0], e.r[31:0], e.dz);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_msb_divisor();
        test_div_zero();
        test_hold();
        test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
